gated_xor_checker: RTL and testbench



---
 rtl/gated_xor_checker.sv | 90 +++++++++
 tb/tb_gated_xor_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gated_xor_checker.sv
// Windowed checker for an enabled-XOR stage: recomputes en&(a^b) each RUN cycle and
// accumulates ones seen, mismatches and the index of the first mismatch.
module gated_xor_checker #(
  parameter int WINDOW = 8,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_count,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             err_flag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] ones_reg;
  logic [CNT_W-1:0] err_reg;
  logic [IDX_W-1:0] first_reg;
  logic             flag_reg;
  logic             mismatch;

  assign mismatch = (q != (en & (a ^ b)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ones_reg  <= '0;
      err_reg   <= '0;
      first_reg <= '0;
      flag_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            idx_reg   <= '0;
            ones_reg  <= '0;
            err_reg   <= '0;
            first_reg <= '0;
            flag_reg  <= 1'b0;
          end
        end
        RUN: begin
          // Both counters saturate at all-ones rather than wrapping.
          if (q && ones_reg != CNT_MAX)
            ones_reg <= ones_reg + 1'b1;
          if (mismatch && err_reg != CNT_MAX)
            err_reg <= err_reg + 1'b1;
          if (mismatch && !flag_reg) begin
            first_reg <= idx_reg;
            flag_reg  <= 1'b1;
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign ones_count    = ones_reg;
  assign err_count     = err_reg;
  assign first_err_idx = first_reg;
  assign err_flag      = flag_reg;

endmodule

// File: tb/tb_gated_xor_checker.sv
// Directed and randomized bench for gated_xor_checker; results compared against a
// counting model built from the recorded sample stream of each run.
module tb_gated_xor_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, en, a, b, q;
  logic       busy, done, err_flag;
  logic [3:0] ones_count, err_count;
  logic [2:0] first_err_idx;

  logic       start2, en2, a2, b2, q2;
  logic       busy2, done2, err_flag2;
  logic [2:0] ones_count2, err_count2;
  logic [3:0] first_err_idx2;

  int checks = 0;
  int errors = 0;

  bit s_en[$], s_a[$], s_b[$], s_q[$];

  gated_xor_checker #(.WINDOW(8), .IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .a(a), .b(b), .q(q),
    .busy(busy), .done(done), .ones_count(ones_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .err_flag(err_flag)
  );

  gated_xor_checker #(.WINDOW(10), .IDX_W(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .en(en2), .a(a2), .b(b2), .q(q2),
    .busy(busy2), .done(done2), .ones_count(ones_count2), .err_count(err_count2),
    .first_err_idx(first_err_idx2), .err_flag(err_flag2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: counts over the recorded window, saturating at max_cnt.
  task automatic check_results(input string tag, input int max_cnt);
    int ones = 0, errs = 0, first = 0;
    bit seen = 0;
    for (int i = 0; i < s_q.size(); i++) begin
      if (s_q[i]) ones++;
      if (s_q[i] != (s_en[i] && (s_a[i] != s_b[i]))) begin
        errs++;
        if (!seen) begin
          seen  = 1;
          first = i;
        end
      end
    end
    if (ones > max_cnt) ones = max_cnt;
    if (errs > max_cnt) errs = max_cnt;
    chk({tag, ".ones"},  32'(ones_count),    32'(ones));
    chk({tag, ".errs"},  32'(err_count),     32'(errs));
    chk({tag, ".first"}, 32'(first_err_idx), 32'(first));
    chk({tag, ".flag"},  32'(err_flag),      32'(seen));
  endtask

  // mode: 0 golden ordered, 1 stuck-at-1, 2 fault at index 5, 3 random with faults.
  task automatic run1(input string tag, input int mode, input bit toggle_start,
                      input bit chained, input bit hold_after);
    logic [2:0] p;
    bit ex;
    s_en.delete(); s_a.delete(); s_b.delete(); s_q.delete();
    if (!chained) begin
      @(negedge clk);
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      start = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s.busy%0d", tag, i), 32'({busy, done}), 32'b10);
      if (i == 0) begin
        chk({tag, ".clr_ones"}, 32'(ones_count), 32'd0);
        chk({tag, ".clr_errs"}, 32'(err_count), 32'd0);
        chk({tag, ".clr_flag"}, 32'({err_flag, first_err_idx}), 32'd0);
      end
      start = toggle_start ? 1'($urandom) : 1'b0;
      if (mode == 3) p = 3'($urandom);
      else           p = 3'(i);
      {en, a, b} = p;
      ex = en && (a != b);
      case (mode)
        1:       q = 1'b1;
        2:       q = (i == 5) ? !ex : ex;
        3:       q = ($urandom_range(0, 3) == 0) ? !ex : ex;
        default: q = ex;
      endcase
      s_en.push_back(en); s_a.push_back(a); s_b.push_back(b); s_q.push_back(q);
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'({busy, done}), 32'b11);
    check_results(tag, 15);
    start = hold_after;
    @(negedge clk);
    chk({tag, ".after"}, 32'({busy, done}), 32'b00);
    check_results({tag, ".hold"}, 15);
    $display("run %s mode=%0d ones=%0d errs=%0d first=%0d flag=%0d",
             tag, mode, ones_count, err_count, first_err_idx, err_flag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; q = 1'b0;
    start2 = 1'b0; en2 = 1'b0; a2 = 1'b0; b2 = 1'b0; q2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.state", 32'({busy, done, err_flag}), 32'd0);
    chk("reset.counts", 32'({ones_count, err_count, first_err_idx}), 32'd0);
    rst_n = 1'b1;

    run1("golden", 0, 1'b0, 1'b0, 1'b0);
    run1("stuck1", 1, 1'b0, 1'b0, 1'b0);
    run1("fault5", 2, 1'b0, 1'b0, 1'b0);
    chk("fault5.spec_first", 32'(first_err_idx), 32'd5);

    // Saturation on the wider-window, narrow-counter instance.
    @(negedge clk);
    start2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("sat.busy%0d", i), 32'({busy2, done2}), 32'b10);
      start2 = 1'b0;
      {en2, a2, b2, q2} = 4'b1100;
    end
    @(negedge clk);
    chk("sat.done", 32'({busy2, done2}), 32'b11);
    chk("sat.errs", 32'(err_count2), 32'd7);
    chk("sat.ones", 32'(ones_count2), 32'd0);
    chk("sat.first", 32'({err_flag2, first_err_idx2}), 32'h10);
    @(negedge clk);
    chk("sat.after", 32'({busy2, done2}), 32'b00);
    $display("run sat errs=%0d ones=%0d", err_count2, ones_count2);

    // Reset on the 4th RUN edge, then reset overriding start.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      {en, a, b, q} = 4'b0001;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.state", 32'({busy, done, err_flag}), 32'd0);
    chk("rst_mid.counts", 32'({ones_count, err_count, first_err_idx}), 32'd0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_prio%0d", i), 32'({busy, done}), 32'b00);
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rst_nodone%0d", i), 32'({busy, done}), 32'b00);
    end
    $display("run reset_mid ok_checks=%0d", checks);

    // Start ignored while busy, then back-to-back runs via held start.
    run1("toggle", 3, 1'b1, 1'b0, 1'b1);
    run1("chain", 3, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++)
      run1($sformatf("rand%0d", r), 3, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
